sha256_block_ctrl: RTL and testbench

Sequencer for the SHA-256 compression round datapath. It accepts one 512-bit message block per START and holds the chaining state H0..H7. It drives the compressor's load, round index and round-enable through 64 rounds, then folds the working variables back into H. It sits between the top-level hash FSM (block/padding handling) and the compressor, with the message-schedule unit and K ROM both indexed by its ROUND output.

---
 rtl/sha256_pkg.sv | 21 ++
 rtl/sha256_block_ctrl.sv | 83 ++++++++
 tb/tb_sha256_block_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 block sequencer.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned SHA256_ROUNDS = 64;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUNDS,
    S_ADD,
    S_FIN
  } state_t;

endpackage

// File: rtl/sha256_block_ctrl.sv
// Sequences one SHA-256 block through the round datapath and folds the
// working variables back into the chaining state H0..H7.
module sha256_block_ctrl
  import sha256_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         FIRST,
  input  logic         W_VALID,
  input  logic [255:0] WV_IN,
  output logic         BUSY,
  output logic         DONE,
  output logic         COMP_LOAD,
  output logic         COMP_EN,
  output logic [5:0]   ROUND,
  output logic [255:0] H_OUT
);

  localparam logic [5:0] LAST_ROUND = 6'(SHA256_ROUNDS - 1);

  state_t       state_q, state_d;
  logic [5:0]   round_q, round_d;
  logic [255:0] h_q, h_d;
  word_t        lane_sum;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      round_q <= '0;
      h_q     <= SHA256_IV;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      h_q     <= h_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    h_d      = h_q;
    lane_sum = '0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LOAD;
          round_d = '0;
          if (FIRST) h_d = SHA256_IV;
        end
      end
      S_LOAD: state_d = S_ROUNDS;
      S_ROUNDS: begin
        if (W_VALID) begin
          if (round_q == LAST_ROUND) begin
            state_d = S_ADD;
            round_d = '0;
          end else begin
            round_d = round_q + 6'd1;
          end
        end
      end
      S_ADD: begin
        // Per-lane 32-bit adds: each lane's carry-out is dropped.
        for (int unsigned j = 0; j < 8; j++) begin
          lane_sum          = h_q[32*j +: 32] + WV_IN[32*j +: 32];
          h_d[32*j +: 32]   = lane_sum;
        end
        state_d = S_FIN;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY      = (state_q == S_LOAD) || (state_q == S_ROUNDS) || (state_q == S_ADD);
  assign DONE      = (state_q == S_FIN);
  assign COMP_LOAD = (state_q == S_LOAD);
  assign COMP_EN   = (state_q == S_ROUNDS) && W_VALID;
  assign ROUND     = round_q;
  assign H_OUT     = h_q;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed bench for sha256_block_ctrl with a stub and a behavioural compressor.
module tb_sha256_block_ctrl;

  logic         CLK = 1'b0;
  logic         RESET, START, FIRST, W_VALID;
  logic [255:0] WV_IN;
  logic         BUSY, DONE, COMP_LOAD, COMP_EN;
  logic [5:0]   ROUND;
  logic [255:0] H_OUT;

  int checks = 0;
  int failures = 0;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  sha256_block_ctrl dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FIRST(FIRST),
    .W_VALID(W_VALID), .WV_IN(WV_IN), .BUSY(BUSY), .DONE(DONE),
    .COMP_LOAD(COMP_LOAD), .COMP_EN(COMP_EN), .ROUND(ROUND), .H_OUT(H_OUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural compressor and schedule table, indexed by ROUND.
  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0]  w_tab [64];
  logic [255:0] st;
  bit           real_mode = 1'b0;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] round_fn(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  task automatic expand(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w_tab[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w_tab[t-15], 7) ^ ror(w_tab[t-15], 18) ^ (w_tab[t-15] >> 3);
      s1 = ror(w_tab[t-2], 17) ^ ror(w_tab[t-2], 19) ^ (w_tab[t-2] >> 10);
      w_tab[t] = s1 + w_tab[t-7] + s0 + w_tab[t-16];
    end
  endtask

  always @(posedge CLK) begin
    if (COMP_LOAD)    st <= H_OUT;
    else if (COMP_EN) st <= round_fn(st, K[ROUND], w_tab[ROUND]);
  end

  assign WV_IN = real_mode ? st : {8{32'h95f61999}};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one block; lat counts edges from the START edge to the first DONE cycle.
  task automatic run_block(input logic first, input int stall_at, input int stall_n,
                           input bit poke_start, output int lat);
    int   exp_r, stalled, bad;
    logic wv;
    START = 1'b1; FIRST = first;
    tick();
    START = 1'b0; FIRST = 1'b0; W_VALID = 1'b1; lat = 1;
    #1;
    check("load_pulse", COMP_LOAD, 1);
    check("load_round", ROUND, 0);
    check("load_en", COMP_EN, 0);
    tick(); lat++;
    exp_r = 0; stalled = 0; bad = 0;
    while (exp_r < 64) begin
      wv = !(exp_r == stall_at && stalled < stall_n);
      if (!wv) stalled++;
      W_VALID = wv;
      START = poke_start && (exp_r == 10);
      #1;
      if (ROUND !== 6'(exp_r) || COMP_EN !== wv || COMP_LOAD !== 1'b0 || BUSY !== 1'b1) bad++;
      tick(); lat++;
      if (wv) exp_r++;
    end
    START = 1'b0; W_VALID = 1'b1;
    check("round_seq", bad, 0);
    check("add_busy", BUSY, 1);
    check("add_round", ROUND, 0);
    while (!DONE && lat < 100) begin tick(); lat++; end
    check("fin_busy", BUSY, 0);
    tick();
    check("done_pulse", DONE, 0);
  endtask

  int lat, n;

  initial begin
    RESET = 1'b1; START = 1'b1; FIRST = 1'b1; W_VALID = 1'b0;
    tick(); tick();
    check("rst_h", H_OUT, IV);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_load", COMP_LOAD, 0);
    check("rst_round", ROUND, 0);
    RESET = 1'b0; START = 1'b0;
    tick();
    check("start_in_reset", BUSY, 0);

    run_block(1'b1, -1, 0, 1'b0, lat);
    check("lat_stub", lat, 67);
    check("stub_h0", H_OUT[255:224], 32'h00000000);
    check("stub_h1", H_OUT[223:192], 32'h515dc81e);
    check("stub_h7", H_OUT[31:0], 32'hf1d6e6b2);

    run_block(1'b1, 17, 3, 1'b0, lat);
    check("lat_stall", lat, 70);
    check("stall_h1", H_OUT[223:192], 32'h515dc81e);

    // Chain from non-IV H, then abandon at ROUND 40.
    START = 1'b1; FIRST = 1'b0;
    tick();
    START = 1'b0; W_VALID = 1'b1; n = 0;
    while (ROUND != 6'd40 && n < 100) begin tick(); n++; end
    check("reach_r40", ROUND, 40);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("abort_busy", BUSY, 0);
    check("abort_round", ROUND, 0);
    check("abort_h", H_OUT, IV);
    check("abort_load", COMP_LOAD, 0);
    check("abort_done", DONE, 0);
    tick();
    check("abort_idle", BUSY, 0);

    run_block(1'b1, -1, 0, 1'b1, lat);
    check("lat_poke", lat, 67);
    check("poke_h1", H_OUT[223:192], 32'h515dc81e);

    real_mode = 1'b1;
    expand({32'h61626380, 448'h0, 32'h00000018});
    run_block(1'b1, -1, 0, 1'b0, lat);
    check("abc_lat", lat, 67);
    check("abc_digest", H_OUT,
          256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);

    expand({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000});
    run_block(1'b1, -1, 0, 1'b0, lat);
    check("blk1_lat", lat, 67);
    expand({480'h0, 32'h000001c0});
    run_block(1'b0, 5, 2, 1'b0, lat);
    check("blk2_lat", lat, 69);
    check("two_block_digest", H_OUT,
          256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
